// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin scheduler that shares one start/done
// binary-to-BCD converter among N_REQ requesters and broadcasts each result
// tagged with the requester id.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   i_req         per-requester request level, held until its result
//   i_num_in      packed operands, requester k at [k*NUM_W +: NUM_W]
//   o_cnv_start   one-cycle start pulse to the converter
//   o_cnv_num     operand presented to the converter
//   i_cnv_done    converter result-valid pulse
//   i_cnv_bcd     converter result, digit k at [4k+3:4k]
//   o_res_valid   one-cycle result strobe
//   o_res_id      requester owning the result
//   o_res_bcd     BCD result (0 on error)
//   o_res_err     result invalid: out of range or converter timeout
//   o_busy        high whenever the scheduler is not idle
module bcd_conv_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned NUM_W   = 27,
    parameter int unsigned MAX_VAL = 99999999,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*NUM_W-1:0]     i_num_in,
    output logic                       o_cnv_start,
    output logic [NUM_W-1:0]           o_cnv_num,
    input  logic                       i_cnv_done,
    input  logic [31:0]                i_cnv_bcd,
    output logic                       o_res_valid,
    output logic [$clog2(N_REQ)-1:0]   o_res_id,
    output logic [31:0]                o_res_bcd,
    output logic                       o_res_err,
    output logic                       o_busy
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [NUM_W-1:0] MAX_NUM  = NUM_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_cur_id;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cnv_start;
    logic [NUM_W-1:0]  r_cnv_num;
    logic              r_res_valid;
    logic [ID_W-1:0]   r_res_id;
    logic [31:0]       r_res_bcd;
    logic              r_res_err;
    logic              r_busy;

    logic              w_grant_vld;
    logic [ID_W-1:0]   w_grant_id;
    logic [ID_W-1:0]   w_idx;
    logic [NUM_W-1:0]  w_sel_num;

    // Round-robin pick: first active request at or after r_rr_ptr, wrapping.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_idx       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_idx = ID_W'((32'(r_rr_ptr) + i) % N_REQ);
            if (!w_grant_vld && i_req[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_idx;
            end
        end
        w_sel_num = i_num_in[32'(w_grant_id) * NUM_W +: NUM_W];
    end

    // Scheduler FSM; r_cnv_num doubles as the latched operand of the current job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_cur_id    <= '0;
            r_cnt       <= '0;
            r_cnv_start <= 1'b0;
            r_cnv_num   <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_bcd   <= '0;
            r_res_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_cur_id <= w_grant_id;
                        r_busy   <= 1'b1;
                        if (w_sel_num <= MAX_NUM) begin
                            r_cnv_num <= w_sel_num;
                            r_state   <= S_ISSUE;
                        end else begin
                            // Out of range: report immediately, converter untouched.
                            r_res_valid <= 1'b1;
                            r_res_id    <= w_grant_id;
                            r_res_bcd   <= '0;
                            r_res_err   <= 1'b1;
                            r_state     <= S_DELIVER;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnv_start <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnv_start <= 1'b0;
                    // A done arriving on the last allowed cycle still wins.
                    if (i_cnv_done) begin
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_cur_id;
                        r_res_bcd   <= i_cnv_bcd;
                        r_res_err   <= 1'b0;
                        r_state     <= S_DELIVER;
                    end else if (r_cnt == CNT_LAST) begin
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_cur_id;
                        r_res_bcd   <= '0;
                        r_res_err   <= 1'b1;
                        r_state     <= S_DELIVER;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DELIVER: begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_rr_ptr    <= (r_cur_id == ID_LAST) ? '0 : r_cur_id + ID_W'(1);
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cnv_start = r_cnv_start;
    assign o_cnv_num   = r_cnv_num;
    assign o_res_valid = r_res_valid;
    assign o_res_id    = r_res_id;
    assign o_res_bcd   = r_res_bcd;
    assign o_res_err   = r_res_err;
    assign o_busy      = r_busy;

endmodule
